// File: rtl/td4_pkg.sv
// rtl/td4_pkg.sv - shared opcode, ALU-select, load-mask and state definitions for the TD4 core
package td4_pkg;

    localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
    localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
    localparam logic [3:0] OP_IN_A     = 4'b0010;
    localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
    localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
    localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
    localparam logic [3:0] OP_IN_B     = 4'b0110;
    localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
    localparam logic [3:0] OP_OUT_B    = 4'b1001;
    localparam logic [3:0] OP_OUT_IM   = 4'b1011;
    localparam logic [3:0] OP_JNC      = 4'b1110;
    localparam logic [3:0] OP_JMP      = 4'b1111;

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b10;
    localparam logic [1:0] SEL_IN   = 2'b01;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    // Active-low strobe masks, bit order {pc, out, b, a}
    localparam logic [3:0] LD_A    = 4'b1110;
    localparam logic [3:0] LD_B    = 4'b1101;
    localparam logic [3:0] LD_OUT  = 4'b1011;
    localparam logic [3:0] LD_PC   = 4'b0111;
    localparam logic [3:0] LD_NONE = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

endpackage

// File: rtl/td4_op_decode.sv
// rtl/td4_op_decode.sv - combinational opcode decode to ALU select, load mask and flags
module td4_op_decode
    import td4_pkg::*;
(
    input  logic [3:0] op,
    input  logic       carry,
    output logic [1:0] sel,
    output logic [3:0] load_n,
    output logic       is_add,
    output logic       illegal
);

    always_comb begin
        sel     = SEL_ZERO;
        load_n  = LD_NONE;
        is_add  = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_MOV_A_IM: begin sel = SEL_ZERO; load_n = LD_A;   end
            OP_MOV_B_IM: begin sel = SEL_ZERO; load_n = LD_B;   end
            OP_MOV_A_B:  begin sel = SEL_B;    load_n = LD_A;   end
            OP_MOV_B_A:  begin sel = SEL_A;    load_n = LD_B;   end
            OP_ADD_A_IM: begin sel = SEL_A;    load_n = LD_A;   is_add = 1'b1; end
            OP_ADD_B_IM: begin sel = SEL_B;    load_n = LD_B;   is_add = 1'b1; end
            OP_IN_A:     begin sel = SEL_IN;   load_n = LD_A;   end
            OP_IN_B:     begin sel = SEL_IN;   load_n = LD_B;   end
            OP_OUT_IM:   begin sel = SEL_ZERO; load_n = LD_OUT; end
            OP_OUT_B:    begin sel = SEL_B;    load_n = LD_OUT; end
            OP_JMP:      begin sel = SEL_ZERO; load_n = LD_PC;  end
            OP_JNC:      begin sel = SEL_ZERO; load_n = carry ? LD_NONE : LD_PC; end
            default:     illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/td4_exec_ctrl.sv
// rtl/td4_exec_ctrl.sv - TD4 multi-cycle execution sequencer: fetch, decode, one-cycle write-back strobes
module td4_exec_ctrl
    import td4_pkg::*;
#(
    parameter int FETCH_WAIT = 0,
    parameter int PC_WIDTH   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                run,
    input  logic                step,
    input  logic                halt_req,
    output logic [PC_WIDTH-1:0] rom_addr,
    input  logic [7:0]          rom_data,
    input  logic [3:0]          alu_sum,
    input  logic                alu_carry,
    output logic [1:0]          sel,
    output logic [3:0]          imm,
    output logic [3:0]          load_n,
    output logic [PC_WIDTH-1:0] pc,
    output logic                carry_flag,
    output logic                halted,
    output logic                illegal,
    output logic                instr_done
);

    localparam logic [1:0] LAST_FETCH = 2'(FETCH_WAIT);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                carry_q, carry_d;
    logic [7:0]          ir_q, ir_d;
    logic [1:0]          wait_q, wait_d;
    logic                step_prev_q, step_prev_d;
    logic                step_pend_q, step_pend_d;
    logic                halt_q, halt_d;
    logic                step_edge;

    logic [1:0] dec_sel;
    logic [3:0] dec_load_n;
    logic       dec_is_add;
    logic       dec_illegal;

    td4_op_decode u_decode (
        .op      (ir_q[7:4]),
        .carry   (carry_q),
        .sel     (dec_sel),
        .load_n  (dec_load_n),
        .is_add  (dec_is_add),
        .illegal (dec_illegal)
    );

    assign rom_addr   = pc_q;
    assign pc         = pc_q;
    assign carry_flag = carry_q;
    assign imm        = ir_q[3:0];
    assign step_edge  = step & ~step_prev_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        carry_d     = carry_q;
        ir_d        = ir_q;
        wait_d      = 2'd0;
        step_prev_d = step;
        step_pend_d = step_pend_q | step_edge;
        halt_d      = halt_q | halt_req;
        sel         = SEL_A;
        load_n      = LD_NONE;
        illegal     = 1'b0;
        instr_done  = 1'b0;
        halted      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    if (tick) state_d = ST_FETCH;
                end else if (step_pend_q || step_edge) begin
                    // The pending request and any edge arriving now are consumed together
                    state_d     = ST_FETCH;
                    step_pend_d = 1'b0;
                end
            end
            ST_FETCH: begin
                if (wait_q == LAST_FETCH) begin
                    ir_d    = rom_data;
                    state_d = ST_EXEC;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ST_EXEC: begin
                sel     = dec_sel;
                state_d = ST_WB;
            end
            ST_WB: begin
                sel        = dec_sel;
                load_n     = dec_load_n;
                illegal    = dec_illegal;
                instr_done = 1'b1;
                pc_d       = dec_load_n[3] ? pc_q + PC_WIDTH'(1) : PC_WIDTH'(alu_sum);
                carry_d    = dec_is_add & alu_carry;
                state_d    = (halt_q || halt_req) ? ST_HALT : ST_IDLE;
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            carry_q     <= 1'b0;
            ir_q        <= 8'd0;
            wait_q      <= 2'd0;
            step_prev_q <= 1'b0;
            step_pend_q <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            carry_q     <= carry_d;
            ir_q        <= ir_d;
            wait_q      <= wait_d;
            step_prev_q <= step_prev_d;
            step_pend_q <= step_pend_d;
            halt_q      <= halt_d;
        end
    end

endmodule

// File: tb/tb_td4_exec_ctrl.sv
// tb/tb_td4_exec_ctrl.sv - self-checking bench for td4_exec_ctrl with FETCH_WAIT 0 and 2
module tb_td4_exec_ctrl;

    localparam int NDUT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, tick, run, step, halt_req, alu_carry;
    logic [3:0] alu_sum;
    logic [7:0] rom [16];

    logic [3:0] rom_addr   [NDUT];
    logic [7:0] rom_data   [NDUT];
    logic [1:0] sel        [NDUT];
    logic [3:0] imm        [NDUT];
    logic [3:0] load_n     [NDUT];
    logic [3:0] pc         [NDUT];
    logic       carry_flag [NDUT];
    logic       halted     [NDUT];
    logic       illegal    [NDUT];
    logic       instr_done [NDUT];

    assign rom_data[0] = rom[rom_addr[0]];
    assign rom_data[1] = rom[rom_addr[1]];

    td4_exec_ctrl #(.FETCH_WAIT(0), .PC_WIDTH(4)) u_dut0 (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .step(step), .halt_req(halt_req),
        .rom_addr(rom_addr[0]), .rom_data(rom_data[0]), .alu_sum(alu_sum), .alu_carry(alu_carry),
        .sel(sel[0]), .imm(imm[0]), .load_n(load_n[0]), .pc(pc[0]), .carry_flag(carry_flag[0]),
        .halted(halted[0]), .illegal(illegal[0]), .instr_done(instr_done[0])
    );

    td4_exec_ctrl #(.FETCH_WAIT(2), .PC_WIDTH(4)) u_dut2 (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .step(step), .halt_req(halt_req),
        .rom_addr(rom_addr[1]), .rom_data(rom_data[1]), .alu_sum(alu_sum), .alu_carry(alu_carry),
        .sel(sel[1]), .imm(imm[1]), .load_n(load_n[1]), .pc(pc[1]), .carry_flag(carry_flag[1]),
        .halted(halted[1]), .illegal(illegal[1]), .instr_done(instr_done[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: m_pos 0 = waiting, 1..flen = fetch, flen+1 = exec, flen+2 = write-back, -1 = halted
    int         flen [NDUT] = '{1, 3};
    int         m_pos   [NDUT];
    logic [3:0] m_pc    [NDUT];
    logic       m_carry [NDUT];
    logic [7:0] m_ir    [NDUT];
    logic       m_pend  [NDUT];
    logic       m_prev  [NDUT];
    logic       m_halt  [NDUT];

    function automatic logic [3:0] exp_mask(input logic [3:0] op, input logic c);
        if (op <= 4'h3) return 4'b1110;
        if (op <= 4'h7) return 4'b1101;
        if (op == 4'h9 || op == 4'hB) return 4'b1011;
        if (op == 4'hF || (op == 4'hE && !c)) return 4'b0111;
        return 4'b1111;
    endfunction

    function automatic logic [1:0] exp_sel(input logic [3:0] op);
        case (op)
            4'h0, 4'h4:       return 2'b00;
            4'h1, 4'h5, 4'h9: return 2'b10;
            4'h2, 4'h6:       return 2'b01;
            default:          return 2'b11;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return !(op == 4'h8 || op == 4'hA || op == 4'hC || op == 4'hD);
    endfunction

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic predict_all();
        logic       e, jump;
        logic [3:0] op;
        for (int k = 0; k < NDUT; k++) begin
            if (rst) begin
                m_pos[k] = 0; m_pc[k] = 4'd0; m_carry[k] = 1'b0; m_ir[k] = 8'd0;
                m_pend[k] = 1'b0; m_prev[k] = 1'b0; m_halt[k] = 1'b0;
            end else begin
                e = step && !m_prev[k];
                m_prev[k] = step;
                if (halt_req) m_halt[k] = 1'b1;
                if (m_pos[k] == 0) begin
                    if (run) begin
                        if (e) m_pend[k] = 1'b1;
                        if (tick) m_pos[k] = 1;
                    end else if (m_pend[k] || e) begin
                        m_pend[k] = 1'b0;
                        m_pos[k]  = 1;
                    end
                end else if (m_pos[k] > 0) begin
                    if (e) m_pend[k] = 1'b1;
                    if (m_pos[k] == flen[k]) m_ir[k] = rom[m_pc[k]];
                    if (m_pos[k] == flen[k] + 2) begin
                        op   = m_ir[k][7:4];
                        jump = (op == 4'hF) || (op == 4'hE && !m_carry[k]);
                        m_pc[k]    = jump ? alu_sum : m_pc[k] + 4'd1;
                        m_carry[k] = (op == 4'h0 || op == 4'h5) ? alu_carry : 1'b0;
                        m_pos[k]   = m_halt[k] ? -1 : 0;
                    end else begin
                        m_pos[k] = m_pos[k] + 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        logic       wb, ex;
        logic [3:0] op;
        for (int k = 0; k < NDUT; k++) begin
            wb = (m_pos[k] == flen[k] + 2);
            ex = (m_pos[k] == flen[k] + 1);
            op = m_ir[k][7:4];
            chk("pc", k, 8'(pc[k]), 8'(m_pc[k]));
            chk("rom_addr", k, 8'(rom_addr[k]), 8'(m_pc[k]));
            chk("carry_flag", k, 8'(carry_flag[k]), 8'(m_carry[k]));
            chk("halted", k, 8'(halted[k]), 8'(m_pos[k] == -1));
            chk("instr_done", k, 8'(instr_done[k]), 8'(wb));
            chk("load_n", k, 8'(load_n[k]), 8'(wb ? exp_mask(op, m_carry[k]) : 4'b1111));
            chk("illegal", k, 8'(illegal[k]), 8'(wb && !is_legal(op)));
            if (wb || ex) begin
                chk("sel", k, 8'(sel[k]), 8'(exp_sel(op)));
                chk("imm", k, 8'(imm[k]), 8'(m_ir[k][3:0]));
            end
        end
    endtask

    // Inputs are set by the caller between cycles; they are sampled at the next rising edge
    task automatic cyc();
        predict_all();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_done(input int k, input int max_cyc, output int n);
        n = 0;
        while (1) begin
            cyc();
            n++;
            if (instr_done[k]) return;
            if (n >= max_cyc) begin
                chk("done_timeout", k, 8'd0, 8'd1);
                return;
            end
        end
    endtask

    int n;
    int cnt [NDUT];

    initial begin
        rst = 1'b1; tick = 1'b0; run = 1'b1; step = 1'b0; halt_req = 1'b0;
        alu_sum = 4'd0; alu_carry = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 8'h35;
        cyc(); cyc();
        rst = 1'b0;
        chk("reset_load_n", 0, 8'(load_n[0]), 8'h0F);
        chk("reset_pc", 0, 8'(pc[0]), 8'h00);
        chk("reset_sel", 0, 8'(sel[0]), 8'h00);
        chk("reset_imm", 0, 8'(imm[0]), 8'h00);
        chk("reset_halted", 1, 8'(halted[1]), 8'h00);

        // Free run, tick every cycle
        rom[0] = 8'h35; rom[1] = 8'h0C; rom[2] = 8'hE7; rom[3] = 8'hFF; rom[15] = 8'hF3;
        alu_sum = 4'd1; alu_carry = 1'b1; tick = 1'b1;
        wait_done(0, 10, n);
        chk("latency_fw0", 0, 8'(n), 8'd3);
        chk("mov_load_n", 0, 8'(load_n[0]), 8'b1110);
        chk("mov_sel", 0, 8'(sel[0]), 8'b11);
        chk("mov_imm", 0, 8'(imm[0]), 8'h5);
        cyc();
        chk("mov_pc", 0, 8'(pc[0]), 8'd1);
        wait_done(0, 10, n);
        chk("add_load_n", 0, 8'(load_n[0]), 8'b1110);
        chk("add_sel", 0, 8'(sel[0]), 8'b00);
        cyc();
        chk("add_carry", 0, 8'(carry_flag[0]), 8'd1);
        wait_done(0, 10, n);
        chk("jnc_load_n", 0, 8'(load_n[0]), 8'b1111);
        cyc();
        chk("jnc_pc", 0, 8'(pc[0]), 8'd3);
        chk("jnc_carry", 0, 8'(carry_flag[0]), 8'd0);
        alu_sum = 4'd15;
        wait_done(0, 10, n);
        cyc();
        chk("jmp15_pc", 0, 8'(pc[0]), 8'd15);
        alu_sum = 4'd3;
        wait_done(0, 10, n);
        chk("jmp_load_n", 0, 8'(load_n[0]), 8'b0111);
        cyc();
        chk("jmp_pc", 0, 8'(pc[0]), 8'd3);
        alu_sum = 4'd15; rom[15] = 8'h80;
        wait_done(0, 10, n);
        cyc();
        wait_done(0, 10, n);
        chk("nop_illegal", 0, 8'(illegal[0]), 8'd1);
        chk("nop_load_n", 0, 8'(load_n[0]), 8'b1111);
        chk("nop_sel", 0, 8'(sel[0]), 8'b11);
        cyc();
        chk("nop_pc_wrap", 0, 8'(pc[0]), 8'd0);

        // Single-step: three spaced edges
        rst = 1'b1; cyc(); rst = 1'b0;
        run = 1'b0; tick = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 8'h35;
        cnt[0] = 0; cnt[1] = 0;
        for (int e = 0; e < 3; e++) begin
            for (int c = 0; c < 10; c++) begin
                step = (c < 2);
                cyc();
                for (int k = 0; k < NDUT; k++) if (instr_done[k]) cnt[k]++;
            end
        end
        for (int k = 0; k < NDUT; k++) begin
            chk("step_count", k, 8'(cnt[k]), 8'd3);
            chk("step_pc", k, 8'(pc[k]), 8'd3);
        end
        // Start edge plus two edges while busy: one extra instruction only
        cnt[0] = 0; cnt[1] = 0;
        for (int c = 0; c < 20; c++) begin
            step = (c == 0 || c == 2 || c == 4);
            cyc();
            for (int k = 0; k < NDUT; k++) if (instr_done[k]) cnt[k]++;
        end
        for (int k = 0; k < NDUT; k++) begin
            chk("step_merge_count", k, 8'(cnt[k]), 8'd2);
            chk("step_merge_pc", k, 8'(pc[k]), 8'd5);
        end

        // Halt requested during fetch
        step = 1'b0; run = 1'b1; tick = 1'b0;
        rst = 1'b1; cyc(); rst = 1'b0;
        cyc();
        tick = 1'b1; cyc();
        halt_req = 1'b1; cyc();
        halt_req = 1'b0; tick = 1'b0;
        wait_done(0, 10, n);
        chk("halt_wb_load_n", 0, 8'(load_n[0]), 8'b1110);
        for (int c = 0; c < 20; c++) begin
            tick = 1'($urandom); step = 1'($urandom);
            cyc();
        end
        for (int k = 0; k < NDUT; k++) begin
            chk("halt_state", k, 8'(halted[k]), 8'd1);
            chk("halt_pc", k, 8'(pc[k]), 8'd1);
        end

        // FETCH_WAIT=2 sampling point and reset during EXEC
        tick = 1'b0; step = 1'b0;
        rst = 1'b1; cyc(); rst = 1'b0;
        rom[0] = 8'h35;
        tick = 1'b1; cyc();
        tick = 1'b0; cyc(); cyc();
        chk("fw0_done", 0, 8'(instr_done[0]), 8'd1);
        chk("fw0_imm", 0, 8'(imm[0]), 8'h5);
        rom[0] = 8'h3A;
        cyc();
        chk("fw2_exec_imm", 1, 8'(imm[1]), 8'hA);
        chk("fw2_exec_load_n", 1, 8'(load_n[1]), 8'hF);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("abort_pc", 1, 8'(pc[1]), 8'd0);
        chk("abort_load_n", 1, 8'(load_n[1]), 8'hF);
        tick = 1'b1; cyc(); tick = 1'b0;
        wait_done(1, 12, n);
        chk("latency_fw2", 1, 8'(n + 1), 8'd5);

        // Randomised traffic against the model
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 49) == 0) run = ~run;
            tick     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) step = ~step;
            halt_req = ($urandom_range(0, 299) == 0);
            alu_sum  = 4'($urandom);
            alu_carry = 1'($urandom);
            if ($urandom_range(0, 7) == 0) rom[$urandom_range(0, 15)] = 8'($urandom);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/td4_exec_ctrl.md
Name: td4_exec_ctrl

Overview:
Multi-cycle execution sequencer for the TD4 4-bit core.
- Owns the program counter and carry flag.
- Fetches the 8-bit instruction from ROM and decodes opcode/immediate.
- Drives the ALU input select, then pulses the active-low load strobes {pc, out, b, a} for exactly one write-back cycle.
- Provides free-run (tick-paced), single-step and halt control, so the datapath can run on the FPGA system clock without a gated clock.

Parameters:
FETCH_WAIT, 0, extra ROM read-latency cycles spent in FETCH (legal 0..3)
PC_WIDTH, 4, program counter / ROM address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tick  in  1  one-cycle enable from clock divider; paces instruction starts in run mode
run  in  1  1 = free run, 0 = single-step mode
step  in  1  level from synchronised push-button; rising edge requests one instruction
halt_req  in  1  request halt after the current instruction
rom_addr  out  PC_WIDTH  ROM address (= pc)
rom_data  in  8  instruction {op[7:4], imm[3:0]}
alu_sum  in  4  ALU result
alu_carry  in  1  ALU carry out
sel  out  2  ALU input select: 00 A, 10 B, 01 input port, 11 zero
imm  out  4  latched immediate to ALU
load_n  out  4  active-low load strobes {pc, out, b, a}
pc  out  PC_WIDTH  program counter
carry_flag  out  1  carry flag register
halted  out  1  core halted
illegal  out  1  one-cycle pulse on undefined opcode
instr_done  out  1  one-cycle pulse on write-back cycle

Behaviour:
- Reset values: state IDLE, pc 0, carry_flag 0, instruction register 0, load_n 1111, sel 00, imm 0, halted 0, illegal 0, instr_done 0, step edge and halt latches cleared. Reset mid-instruction aborts with no load pulse.
- States: IDLE, FETCH, EXEC, WB, HALT.
- IDLE -> FETCH:
  - run=1: on tick=1.
  - run=0: on pending step edge; the edge is consumed here.
  - Step edges seen while not in IDLE are held as one pending request; extra edges are dropped.
- FETCH: rom_addr=pc. Lasts 1+FETCH_WAIT cycles. The instruction register latches rom_data on the last FETCH cycle.
- EXEC: 1 cycle. sel and imm are driven from the instruction register; the ALU settles. load_n stays 1111.
- WB: 1 cycle.
  - load_n is driven with the opcode mask: MOV A,Im / MOV A,B / ADD A,Im / IN A = 1110; MOV B,* / ADD B,Im / IN B = 1101; OUT Im / OUT B = 1011; JMP = 0111; JNC = 0111 if carry_flag=0, else 1111.
  - sel per opcode: MOV A,Im 11; MOV B,Im 11; MOV A,B 10; MOV B,A 00; ADD A 00; ADD B 10; IN A/B 01; OUT Im 11; OUT B 10; JMP 11; JNC 11.
  - instr_done=1.
- At the WB clock edge:
  - pc <= alu_sum if load_n[3]=0, else pc+1. Wraps 15 -> 0.
  - carry_flag <= alu_carry for ADD A/ADD B; cleared to 0 for every other opcode, including JNC and undefined.
- Undefined opcode (any not listed): NOP. load_n 1111, sel 11, pc+1, illegal=1 during WB.
- WB -> HALT if halt latch set, else IDLE. halt_req is latched on any cycle, so an instruction in flight always completes.
- HALT: halted=1, load_n 1111, no fetch. Exits only by rst. In HALT, tick and step are ignored.
- If run changes mid-instruction, the new value takes effect at the next IDLE.
- Instruction latency: 3+FETCH_WAIT cycles from leaving IDLE to WB inclusive.

Decomposition:
- Shared package td4_pkg holds:
  - opcode localparams (OP_MOV_A_IM 4'b0011 ... OP_JNC 4'b1110, OP_JMP 4'b1111);
  - sel encodings SEL_A/B/IN/ZERO;
  - load masks LD_A 1110, LD_B 1101, LD_OUT 1011, LD_PC 0111, LD_NONE 1111;
  - state encoding.
- Sub-module td4_op_decode: combinational, full case with default, op+carry -> {sel, load_n, is_add, illegal}. The FSM instantiates it on the instruction register.

Test Plan:
- Reset, then run=1, tick every cycle, ROM[0]=0x35 (MOV A,5) -> WB at cycle 3, load_n=1110, sel=11, imm=5, pc 0->1.
- ROM[1]=0x0C (ADD A,12), alu_sum=1, alu_carry=1 -> load_n=1110, sel=00, carry_flag=1. Next ROM[2]=0xE7 (JNC 7) -> load_n=1111, pc=3, carry_flag=0.
- JMP 0xF3 at pc=15 with alu_sum=3 -> load_n=0111, pc=3. Then NOP opcode 0x8 at pc=15 -> illegal pulse, pc wraps to 0.
- run=0, three step edges spaced 10 cycles apart -> exactly three instr_done pulses, pc=3. Two edges during one instruction -> only one extra instruction.
- halt_req pulsed during FETCH -> instruction completes with its load pulse, then halted=1 and pc frozen. tick/step ignored until rst.
- FETCH_WAIT=2 -> the instruction register samples rom_data 3 cycles after FETCH entry; rst asserted in EXEC -> load_n stays 1111, pc=0.
